// File: rtl/tx_trellis_encoder.sv
// Transmit trellis encoder: optional side-stream scrambler, 8-state rate-2/3
// convolutional encoder and mapping onto four signed 5-level PAM lane samples.
module tx_trellis_encoder #(
    parameter int          LEVEL_SCALE = 32,
    parameter bit          SCRAMBLE_EN = 1'b1,
    parameter logic [32:0] SCR_SEED    = 33'h1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    input  logic [7:0] io_in_bits,
    input  logic       io_in_last,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [7:0] io_out_bits_0,
    output logic [7:0] io_out_bits_1,
    output logic [7:0] io_out_bits_2,
    output logic [7:0] io_out_bits_3,
    output logic       io_out_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] SCALE8 = 8'(LEVEL_SCALE);

    // Modulo-256 arithmetic gives the same low byte as the full signed product.
    function automatic logic [7:0] lane_sample(input logic [1:0] k, input logic p);
        logic [2:0] idx;
        logic [7:0] lvl;
        idx = {1'b0, k} + {2'b00, p};
        lvl = {5'b00000, idx} - 8'd2;
        return 8'(lvl * SCALE8);
    endfunction

    state_t      state_r, state_next_s;
    logic        flush_cnt_r, flush_cnt_next_s;
    logic [2:0]  cs_r, cs_next_s;
    logic [32:0] lfsr_r, lfsr_next_s;
    logic        out_valid_r, out_data_r;
    logic [7:0]  out_bits_r [4];

    logic        load_s, accept_s, p_s, data_s;
    logic [7:0]  scr_s, sd_s;
    logic [7:0]  lane_s [4];

    assign load_s      = !out_valid_r || io_out_ready;
    assign io_in_ready = reset && load_s && (state_r != ST_FLUSH);
    assign accept_s    = io_in_valid && io_in_ready;

    // Word source selection, scrambler/encoder next state and lane mapping.
    always_comb begin
        scr_s       = SCRAMBLE_EN ? lfsr_r[7:0] : 8'h00;
        sd_s        = scr_s;
        data_s      = 1'b0;
        if (accept_s) begin
            sd_s   = io_in_bits ^ scr_s;
            data_s = 1'b1;
        end else if (state_r == ST_FLUSH) begin
            sd_s   = {cs_r[1], cs_r[0], scr_s[5:0]};
            data_s = 1'b0;
        end else begin
            sd_s   = scr_s;
            data_s = 1'b0;
        end
        p_s         = cs_r[0];
        cs_next_s   = {sd_s[7] ^ cs_r[1], sd_s[6] ^ cs_r[0], cs_r[2]};
        lfsr_next_s = {lfsr_r[31:0], lfsr_r[32] ^ lfsr_r[12]};
        for (int i = 0; i < 4; i++) begin
            lane_s[i] = lane_sample(sd_s[2*i +: 2], p_s);
        end
    end

    // FSM next-state: packet framing and the two-word trellis termination.
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s     = io_in_last ? ST_FLUSH : ST_DATA;
                    flush_cnt_next_s = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept_s && io_in_last) begin
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = 1'b0;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_FLUSH: begin
                if (load_s && flush_cnt_r) begin
                    state_next_s     = ST_IDLE;
                    flush_cnt_next_s = 1'b0;
                end else if (load_s) begin
                    flush_cnt_next_s = 1'b1;
                end else begin
                    flush_cnt_next_s = flush_cnt_r;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                flush_cnt_next_s = 1'b0;
            end
        endcase
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            flush_cnt_r <= flush_cnt_next_s;
        end
    end

    // Datapath registers advance only on load; a stall freezes everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_r        <= 3'b000;
            lfsr_r      <= SCR_SEED;
            out_valid_r <= 1'b0;
            out_data_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                out_bits_r[i] <= 8'h00;
            end
        end else if (load_s) begin
            cs_r        <= cs_next_s;
            lfsr_r      <= lfsr_next_s;
            out_valid_r <= 1'b1;
            out_data_r  <= data_s;
            for (int i = 0; i < 4; i++) begin
                out_bits_r[i] <= lane_s[i];
            end
        end
    end

    assign io_out_valid  = out_valid_r;
    assign io_out_data   = out_data_r;
    assign io_out_bits_0 = out_bits_r[0];
    assign io_out_bits_1 = out_bits_r[1];
    assign io_out_bits_2 = out_bits_r[2];
    assign io_out_bits_3 = out_bits_r[3];

endmodule
